// File: rtl/bsk_bus_pkg.sv
// Shared constants and types for the BSK PRD parallel register bus master.
package bsk_bus_pkg;

  // Chip-select codes presented on oCS
  localparam logic [3:0] CS_16_01 = 4'b1011;  // low-command unit
  localparam logic [3:0] CS_32_17 = 4'b1001;  // high-command unit
  localparam logic [3:0] CS_IDLE  = 4'b0000;  // bus deselected

  // Register addresses inside a PRD unit
  localparam logic [1:0] A_COM_LO = 2'd0;
  localparam logic [1:0] A_COM_HI = 2'd1;
  localparam logic [1:0] A_IND    = 2'd2;
  localparam logic [1:0] A_CTRL   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_TURN
  } state_t;

  // Map the request unit bit onto its chip-select code
  function automatic logic [3:0] cs_for_unit(input logic unit);
    return unit ? CS_32_17 : CS_16_01;
  endfunction

endpackage

// File: rtl/bsk_bus_iobuf.sv
// 16-bit tristate data-bus driver with a registered read sample.
module bsk_bus_iobuf (
  input  logic        clk,
  input  logic        iRes,
  input  logic        i_oe,
  input  logic [15:0] i_data,
  input  logic        i_sample,
  output logic [15:0] o_q,
  inout  wire  [15:0] bD
);

  logic [15:0] r_q;

  assign bD  = i_oe ? i_data : 16'hzzzz;
  assign o_q = r_q;

  // Capture the bus on request; the value is held until the next sample
  always_ff @(posedge clk) begin
    if (iRes) begin
      r_q <= '0;
    end else if (i_sample) begin
      r_q <= bD;
    end
  end

endmodule

// File: rtl/bsk_bus_master.sv
// Host-side BSK PRD bus initiator: one request becomes one timed bus cycle.
module bsk_bus_master #(
  parameter int unsigned T_SETUP  = 1,
  parameter int unsigned T_STROBE = 2,
  parameter int unsigned T_HOLD   = 1,
  parameter int unsigned T_TURN   = 1
) (
  input  logic        clk,
  input  logic        iRes,
  input  logic        iReqValid,
  input  logic        iReqWr,
  input  logic        iReqUnit,
  input  logic [1:0]  iReqAddr,
  input  logic [15:0] iReqData,
  output logic        oReqReady,
  output logic        oRspValid,
  output logic [15:0] oRspData,
  output logic [3:0]  oCS,
  output logic [1:0]  oA,
  output logic        oRd,
  output logic        oWr,
  inout  wire  [15:0] bD
);

  import bsk_bus_pkg::*;

  // Phase counter reload values (counter counts down to zero inside a phase)
  localparam logic [3:0] L_SETUP  = 4'(T_SETUP - 1);
  localparam logic [3:0] L_STROBE = 4'(T_STROBE - 1);
  localparam logic [3:0] L_HOLD   = 4'(T_HOLD - 1);
  localparam logic [3:0] L_TURN   = 4'(T_TURN - 1);
  localparam logic       TURN_EN  = (T_TURN != 0);

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [3:0]  r_cs, w_cs_next;
  logic [1:0]  r_a, w_a_next;
  logic        r_rd, w_rd_next;
  logic        r_wr, w_wr_next;
  logic        r_oe, w_oe_next;
  logic        r_rsp, w_rsp_next;
  logic        r_ready, w_ready_next;
  logic        r_is_wr;
  logic [15:0] r_data;
  logic        w_accept;
  logic        w_sample;
  logic [15:0] w_rsp_data;

  // Next-state and next-output decode; every bus output is a register
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cs_next    = r_cs;
    w_a_next     = r_a;
    w_rd_next    = 1'b1;
    w_wr_next    = 1'b1;
    w_oe_next    = r_oe;
    w_accept     = 1'b0;
    w_sample     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iReqValid) begin
          w_accept     = 1'b1;
          w_state_next = ST_SETUP;
          w_cnt_next   = L_SETUP;
          w_cs_next    = cs_for_unit(iReqUnit);
          w_a_next     = iReqAddr;
          w_oe_next    = iReqWr;
        end
      end
      ST_SETUP: begin
        if (r_cnt == 4'd0) begin
          w_state_next = ST_STROBE;
          w_cnt_next   = L_STROBE;
          w_rd_next    = r_is_wr;
          w_wr_next    = ~r_is_wr;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_STROBE: begin
        if (r_cnt == 4'd0) begin
          // Last low cycle: the slave's read data is captured at this edge
          w_state_next = ST_HOLD;
          w_cnt_next   = L_HOLD;
          w_sample     = ~r_is_wr;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
          w_rd_next  = r_is_wr;
          w_wr_next  = ~r_is_wr;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_cs_next = CS_IDLE;
          w_a_next  = 2'b00;
          w_oe_next = 1'b0;
          if (r_is_wr || !TURN_EN) begin
            w_state_next = ST_IDLE;
          end else begin
            w_state_next = ST_TURN;
            w_cnt_next   = L_TURN;
          end
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      ST_TURN: begin
        if (r_cnt == 4'd0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    // Response flags the final HOLD cycle; ready mirrors the IDLE state
    w_rsp_next   = (w_state_next == ST_HOLD) && (w_cnt_next == 4'd0);
    w_ready_next = (w_state_next == ST_IDLE);
  end

  // State, phase counter, bus outputs and the latched request
  always_ff @(posedge clk) begin
    if (iRes) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_cs    <= CS_IDLE;
      r_a     <= 2'b00;
      r_rd    <= 1'b1;
      r_wr    <= 1'b1;
      r_oe    <= 1'b0;
      r_rsp   <= 1'b0;
      r_ready <= 1'b1;
      r_is_wr <= 1'b0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_cs    <= w_cs_next;
      r_a     <= w_a_next;
      r_rd    <= w_rd_next;
      r_wr    <= w_wr_next;
      r_oe    <= w_oe_next;
      r_rsp   <= w_rsp_next;
      r_ready <= w_ready_next;
      if (w_accept) begin
        r_is_wr <= iReqWr;
        r_data  <= iReqData;
      end
    end
  end

  bsk_bus_iobuf u_iobuf (
    .clk      (clk),
    .iRes     (iRes),
    .i_oe     (r_oe),
    .i_data   (r_data),
    .i_sample (w_sample),
    .o_q      (w_rsp_data),
    .bD       (bD)
  );

  assign oReqReady = r_ready;
  assign oRspValid = r_rsp;
  assign oRspData  = w_rsp_data;
  assign oCS       = r_cs;
  assign oA        = r_a;
  assign oRd       = r_rd;
  assign oWr       = r_wr;

endmodule

// File: tb/tb_bsk_bus_master.sv
// Directed bench for bsk_bus_master with a small PRD slave model on the bus.
module tb_bsk_bus_master;

  import bsk_bus_pkg::*;

  logic        clk;
  logic        iRes;
  logic        iReqValid;
  logic        iReqValid2;
  logic        iReqWr;
  logic        iReqUnit;
  logic [1:0]  iReqAddr;
  logic [15:0] iReqData;

  logic        oReqReady, oRspValid, oRd, oWr;
  logic [15:0] oRspData;
  logic [3:0]  oCS;
  logic [1:0]  oA;
  logic        oReqReady2, oRspValid2, oRd2, oWr2;
  logic [15:0] oRspData2;
  logic [3:0]  oCS2;
  logic [1:0]  oA2;

  // Released bus lines float high so "not driven" is observable as 16'hFFFF
  tri1 [15:0] bD;
  tri1 [15:0] bD2;

  int checks   = 0;
  int failures = 0;
  logic [15:0] ind = 16'h0000;

  bsk_bus_master dut (
    .clk(clk), .iRes(iRes), .iReqValid(iReqValid), .iReqWr(iReqWr),
    .iReqUnit(iReqUnit), .iReqAddr(iReqAddr), .iReqData(iReqData),
    .oReqReady(oReqReady), .oRspValid(oRspValid), .oRspData(oRspData),
    .oCS(oCS), .oA(oA), .oRd(oRd), .oWr(oWr), .bD(bD)
  );

  bsk_bus_master #(.T_SETUP(3), .T_STROBE(5), .T_HOLD(2), .T_TURN(0)) dut2 (
    .clk(clk), .iRes(iRes), .iReqValid(iReqValid2), .iReqWr(iReqWr),
    .iReqUnit(iReqUnit), .iReqAddr(iReqAddr), .iReqData(iReqData),
    .oReqReady(oReqReady2), .oRspValid(oRspValid2), .oRspData(oRspData2),
    .oCS(oCS2), .oA(oA2), .oRd(oRd2), .oWr(oWr2), .bD(bD2)
  );

  // PRD slave model: fixed read values per unit/address
  function automatic logic [15:0] prd_read(input logic [3:0] cs, input logic [1:0] a);
    if (cs == CS_16_01 && a == A_CTRL) return 16'hA44A;
    if (cs == CS_32_17 && a == A_COM_LO) return 16'h5AA5;
    return 16'h0000;
  endfunction

  assign bD  = (oRd == 1'b0)  ? prd_read(oCS, oA)   : 16'hzzzz;
  assign bD2 = (oRd2 == 1'b0) ? prd_read(oCS2, oA2) : 16'hzzzz;

  // Slave latches on the write-strobe rising edge; indication shows the inverted word
  always @(posedge oWr) begin
    if (oCS == CS_16_01 && oA == A_IND) ind <= ~bD;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge; strobes must never overlap
  task automatic step();
    @(posedge clk);
    #1;
    chk("no_overlap", {31'b0, (oRd | oWr) & (oRd2 | oWr2)}, 32'd1);
  endtask

  task automatic bus_chk(input string tag, input logic [3:0] cs, input logic [1:0] a,
                         input logic rd, input logic wr, input logic rdy, input logic rsp);
    chk({tag, ".cs"},  {28'b0, oCS}, {28'b0, cs});
    chk({tag, ".a"},   {30'b0, oA}, {30'b0, a});
    chk({tag, ".rd"},  {31'b0, oRd}, {31'b0, rd});
    chk({tag, ".wr"},  {31'b0, oWr}, {31'b0, wr});
    chk({tag, ".rdy"}, {31'b0, oReqReady}, {31'b0, rdy});
    chk({tag, ".rsp"}, {31'b0, oRspValid}, {31'b0, rsp});
  endtask

  task automatic bd_chk(input string tag, input logic [15:0] exp);
    chk({tag, ".bD"}, {16'b0, bD}, {16'b0, exp});
  endtask

  initial begin
    int rd_low;
    int rsp_k;
    int waited;
    iRes = 1'b1; iReqValid = 1'b0; iReqValid2 = 1'b0; iReqWr = 1'b0;
    iReqUnit = 1'b0; iReqAddr = 2'd0; iReqData = 16'h0000;

    // Reset values
    step(); step();
    bus_chk("reset", CS_IDLE, 2'd0, 1, 1, 1, 0);
    bd_chk("reset", 16'hFFFF);
    chk("reset.rspdata", {16'b0, oRspData}, 32'h0);
    iRes = 1'b0;
    step();
    $display("txn reset done");

    // Write unit 0, A_IND, 16'h1111; request inputs change after accept and must be ignored
    iReqValid = 1'b1; iReqWr = 1'b1; iReqUnit = 1'b0; iReqAddr = A_IND; iReqData = 16'h1111;
    step();
    iReqValid = 1'b0; iReqData = 16'hDEAD; iReqAddr = 2'd0; iReqUnit = 1'b1;
    bus_chk("wr.k1", CS_16_01, A_IND, 1, 1, 0, 0); bd_chk("wr.k1", 16'h1111); step();
    bus_chk("wr.k2", CS_16_01, A_IND, 1, 0, 0, 0); bd_chk("wr.k2", 16'h1111); step();
    bus_chk("wr.k3", CS_16_01, A_IND, 1, 0, 0, 0); bd_chk("wr.k3", 16'h1111); step();
    bus_chk("wr.k4", CS_16_01, A_IND, 1, 1, 0, 1); bd_chk("wr.k4", 16'h1111); step();
    bus_chk("wr.k5", CS_IDLE, 2'd0, 1, 1, 1, 0);   bd_chk("wr.k5", 16'hFFFF);
    chk("wr.ind", {16'b0, ind}, 32'hEEEE);
    chk("wr.rspdata_kept", {16'b0, oRspData}, 32'h0);
    $display("txn write unit0 addr2 data 1111 ind=%h", ind);

    // Read unit 0, A_CTRL: slave returns 16'hA44A, one TURN cycle afterwards
    iReqValid = 1'b1; iReqWr = 1'b0; iReqUnit = 1'b0; iReqAddr = A_CTRL;
    step();
    iReqValid = 1'b0;
    bus_chk("rd.k1", CS_16_01, A_CTRL, 1, 1, 0, 0); bd_chk("rd.k1", 16'hFFFF); step();
    bus_chk("rd.k2", CS_16_01, A_CTRL, 0, 1, 0, 0); bd_chk("rd.k2", 16'hA44A); step();
    bus_chk("rd.k3", CS_16_01, A_CTRL, 0, 1, 0, 0); bd_chk("rd.k3", 16'hA44A); step();
    bus_chk("rd.k4", CS_16_01, A_CTRL, 1, 1, 0, 1); bd_chk("rd.k4", 16'hFFFF);
    chk("rd.rspdata", {16'b0, oRspData}, 32'hA44A); step();
    bus_chk("rd.k5", CS_IDLE, 2'd0, 1, 1, 0, 0);    bd_chk("rd.k5", 16'hFFFF); step();
    bus_chk("rd.k6", CS_IDLE, 2'd0, 1, 1, 1, 0);
    $display("txn read unit0 addr3 data %h", oRspData);

    // Unit select: high-command unit read addr 0
    iReqValid = 1'b1; iReqWr = 1'b0; iReqUnit = 1'b1; iReqAddr = A_COM_LO;
    step();
    iReqValid = 1'b0;
    bus_chk("us.k1", CS_32_17, A_COM_LO, 1, 1, 0, 0); step();
    bus_chk("us.k2", CS_32_17, A_COM_LO, 0, 1, 0, 0); step();
    bus_chk("us.k3", CS_32_17, A_COM_LO, 0, 1, 0, 0); step();
    bus_chk("us.k4", CS_32_17, A_COM_LO, 1, 1, 0, 1);
    chk("us.rspdata", {16'b0, oRspData}, 32'h5AA5); step();
    bus_chk("us.k5", CS_IDLE, 2'd0, 1, 1, 0, 0); step();
    bus_chk("us.k6", CS_IDLE, 2'd0, 1, 1, 1, 0);
    $display("txn read unit1 addr0 data %h", oRspData);

    // Back-to-back: valid held high, write then read; requests while busy are not taken
    iReqValid = 1'b1; iReqWr = 1'b1; iReqUnit = 1'b0; iReqAddr = A_COM_HI; iReqData = 16'h2222;
    step();
    iReqWr = 1'b0; iReqAddr = A_CTRL;
    bus_chk("b2b.k1", CS_16_01, A_COM_HI, 1, 1, 0, 0); bd_chk("b2b.k1", 16'h2222); step();
    bus_chk("b2b.k2", CS_16_01, A_COM_HI, 1, 0, 0, 0); step();
    bus_chk("b2b.k3", CS_16_01, A_COM_HI, 1, 0, 0, 0); step();
    bus_chk("b2b.k4", CS_16_01, A_COM_HI, 1, 1, 0, 1); step();
    bus_chk("b2b.k5", CS_IDLE, 2'd0, 1, 1, 1, 0); step();
    iReqValid = 1'b0;
    bus_chk("b2b.k6", CS_16_01, A_CTRL, 1, 1, 0, 0); bd_chk("b2b.k6", 16'hFFFF); step();
    bus_chk("b2b.k7", CS_16_01, A_CTRL, 0, 1, 0, 0); step();
    bus_chk("b2b.k8", CS_16_01, A_CTRL, 0, 1, 0, 0); step();
    bus_chk("b2b.k9", CS_16_01, A_CTRL, 1, 1, 0, 1);
    chk("b2b.rspdata", {16'b0, oRspData}, 32'hA44A); step();
    bus_chk("b2b.k10", CS_IDLE, 2'd0, 1, 1, 0, 0); step();
    bus_chk("b2b.k11", CS_IDLE, 2'd0, 1, 1, 1, 0);
    $display("txn back-to-back write 2222 then read %h", oRspData);

    // Reset during the STROBE phase of a write
    iReqValid = 1'b1; iReqWr = 1'b1; iReqUnit = 1'b0; iReqAddr = A_COM_LO; iReqData = 16'h3333;
    step();
    iReqValid = 1'b0;
    step();
    bus_chk("rst.k2", CS_16_01, A_COM_LO, 1, 0, 0, 0); bd_chk("rst.k2", 16'h3333);
    iRes = 1'b1;
    step();
    bus_chk("rst.k3", CS_IDLE, 2'd0, 1, 1, 1, 0); bd_chk("rst.k3", 16'hFFFF);
    iRes = 1'b0;
    step();
    bus_chk("rst.k4", CS_IDLE, 2'd0, 1, 1, 1, 0); step();
    bus_chk("rst.k5", CS_IDLE, 2'd0, 1, 1, 1, 0);
    $display("txn reset mid-write dropped");

    // Parameter sweep on dut2 (3/5/2/0): strobe width 5, latency 10, immediate re-accept
    iReqValid2 = 1'b1; iReqWr = 1'b0; iReqUnit = 1'b0; iReqAddr = A_CTRL;
    rd_low = 0; rsp_k = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (oRd2 == 1'b0) rd_low++;
      if (oRspValid2 && rsp_k == 0) rsp_k = k;
      if (k == 10) chk("sw.rspdata", {16'b0, oRspData2}, 32'hA44A);
      if (k == 11) chk("sw.k11.rdy", {31'b0, oReqReady2}, 32'd1);
      if (k == 12) begin
        chk("sw.k12.rdy", {31'b0, oReqReady2}, 32'd0);
        chk("sw.k12.cs", {28'b0, oCS2}, {28'b0, CS_16_01});
        iReqValid2 = 1'b0;
      end
    end
    chk("sw.strobe_width", rd_low, 32'd5);
    chk("sw.latency", rsp_k, 32'd10);
    waited = 0;
    while (!oRspValid2 && waited < 30) begin
      step();
      waited++;
    end
    chk("sw.second_rsp_seen", {31'b0, oRspValid2}, 32'd1);
    step();
    chk("sw.idle_after", {31'b0, oReqReady2}, 32'd1);
    $display("txn sweep read latency=%0d strobe=%0d", rsp_k, rd_low);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
